// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline control logic: opcodes, the NOP encoding,
// sequencer states and the bundle of per-stage enable/flush controls.
package core_ctrl_pkg;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_S      = 7'b0100011;
    localparam logic [6:0]  OP_B      = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_ADVANCE = '{
        pc_en:         1'b1,
        if_id_en:      1'b1,
        if_id_flush:   1'b0,
        id_ex_en:      1'b1,
        id_ex_flush:   1'b0,
        ex_mem_en:     1'b1,
        mem_wb_bubble: 1'b0
    };

    // U/J formats carry no rs1 field; bits [19:15] there are immediate bits.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes from hazard
// priorities, a wrong-path fetch drop FSM, debug counters and a hang watchdog.
module hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_instr,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_valid,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    hz_state_t       r_state;
    hz_state_t       w_state_nxt;
    hz_ctrl_t        w_ctrl;
    logic            w_redirect;
    logic            w_mem_wait;
    logic            w_load_use;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [WD_W-1:0] r_wd;
    logic            r_hang;

    assign w_opcode   = if_id_instr[6:0];
    assign w_rs1      = if_id_instr[19:15];
    assign w_rs2      = if_id_instr[24:20];
    assign w_mem_wait = mem_access && !dmem_ready;
    assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                        ((uses_rs1(w_opcode) && (id_ex_rd == w_rs1)) ||
                         (uses_rs2(w_opcode) && (id_ex_rd == w_rs2)));

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_ctrl      = CTRL_ADVANCE;
        w_state_nxt = r_state;
        w_redirect  = 1'b0;

        if (!rst) begin
            w_ctrl      = '0;
            w_state_nxt = RUN;
        end else if (w_mem_wait) begin
            // EX is frozen, so a taken branch there is re-presented after release.
            w_ctrl.pc_en         = 1'b0;
            w_ctrl.if_id_en      = 1'b0;
            w_ctrl.id_ex_en      = 1'b0;
            w_ctrl.ex_mem_en     = 1'b0;
            w_ctrl.mem_wb_bubble = 1'b1;
            if ((r_state == DROP) && imem_valid) begin
                w_state_nxt = RUN;
            end
        end else if (ex_branch_taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            w_redirect         = 1'b1;
            if ((r_state == DROP) || !imem_valid) begin
                w_state_nxt = DROP;
            end
        end else if (r_state == DROP) begin
            w_ctrl.pc_en       = 1'b0;
            w_ctrl.if_id_flush = 1'b1;
            if (imem_valid) begin
                w_state_nxt = RUN;
            end
        end else if (w_load_use) begin
            w_ctrl.pc_en       = 1'b0;
            w_ctrl.if_id_en    = 1'b0;
            w_ctrl.id_ex_flush = 1'b1;
        end else if (!imem_valid) begin
            w_ctrl.pc_en       = 1'b0;
            w_ctrl.if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Watchdog parks at TIMEOUT; the flag it raises is cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd   <= '0;
            r_hang <= 1'b0;
        end else if (w_ctrl.pc_en) begin
            r_wd <= '0;
        end else begin
            if (r_wd != WD_W'(TIMEOUT)) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (r_wd == WD_W'(TIMEOUT - 1)) begin
                r_hang <= 1'b1;
            end
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!w_ctrl.pc_en),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_redirect),
        .count (flush_cnt)
    );

    assign pc_en         = w_ctrl.pc_en;
    assign if_id_en      = w_ctrl.if_id_en;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_ex_en      = w_ctrl.id_ex_en;
    assign id_ex_flush   = w_ctrl.id_ex_flush;
    assign ex_mem_en     = w_ctrl.ex_mem_en;
    assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign hang_err      = r_hang;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for hazard_ctrl, compared against
// a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctrl;
    import core_ctrl_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1024;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      if_id_instr = NOP_INSTR;
    logic             id_ex_mem_read = 1'b0;
    logic [4:0]       id_ex_rd = 5'd0;
    logic             ex_branch_taken = 1'b0;
    logic             imem_valid = 1'b1;
    logic             mem_access = 1'b0;
    logic             dmem_ready = 1'b1;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             hang_err;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: whether a wrong-path fetch is still outstanding, counts, watchdog run.
    bit   m_drop  = 1'b0;
    int   m_stall = 0;
    int   m_flush = 0;
    int   m_run   = 0;
    bit   m_hang  = 1'b0;

    logic [6:0] last_ctrl;
    logic [6:0] obs_ctrl;

    // Observed control order: {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble}
    localparam logic [6:0] C_NORMAL   = 7'b1101010;
    localparam logic [6:0] C_LOADUSE  = 7'b0001110;
    localparam logic [6:0] C_REDIRECT = 7'b1111110;
    localparam logic [6:0] C_FREEZE   = 7'b0000001;
    localparam logic [6:0] C_DROP     = 7'b0111010;

    logic [6:0] rand_ops [8];

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_instr     (if_id_instr),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_valid      (imem_valid),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .hang_err        (hang_err)
    );

    always #5 clk = ~clk;

    assign obs_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected controls for the current inputs, following the priority list directly.
    function automatic void model_eval(output logic [6:0] ctrl, output bit redir, output bit drop_nxt);
        logic [6:0] op;
        bit reads1, reads2, load_use;
        op       = if_id_instr[6:0];
        reads1   = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        reads2   = (op == OP_R || op == OP_S || op == OP_B);
        load_use = id_ex_mem_read && (id_ex_rd != 0) &&
                   ((reads1 && id_ex_rd == if_id_instr[19:15]) ||
                    (reads2 && id_ex_rd == if_id_instr[24:20]));
        redir    = 1'b0;
        drop_nxt = m_drop;
        if (mem_access && !dmem_ready) begin
            ctrl = C_FREEZE;
            if (imem_valid) drop_nxt = 1'b0;
        end else if (ex_branch_taken) begin
            ctrl  = C_REDIRECT;
            redir = 1'b1;
            drop_nxt = m_drop || !imem_valid;
        end else if (m_drop) begin
            ctrl = C_DROP;
            drop_nxt = !imem_valid;
        end else if (load_use) begin
            ctrl = C_LOADUSE;
        end else if (!imem_valid) begin
            ctrl = C_DROP;
        end else begin
            ctrl = C_NORMAL;
        end
    endfunction

    task automatic cyc(input logic [31:0] instr, input logic ld, input logic [4:0] rd,
                       input logic br, input logic iv, input logic ma, input logic dr);
        logic [6:0] e_ctrl;
        bit e_redir, e_drop;
        @(negedge clk);
        if_id_instr     = instr;
        id_ex_mem_read  = ld;
        id_ex_rd        = rd;
        ex_branch_taken = br;
        imem_valid      = iv;
        mem_access      = ma;
        dmem_ready      = dr;
        #1;
        model_eval(e_ctrl, e_redir, e_drop);
        last_ctrl = obs_ctrl;
        check("ctrl", 64'(obs_ctrl), 64'(e_ctrl));
        @(posedge clk);
        #1;
        if (!e_ctrl[6]) begin
            if (m_stall < CNT_MAX) m_stall++;
            m_run++;
            if (m_run >= TIMEOUT) m_hang = 1'b1;
        end else begin
            m_run = 0;
        end
        if (e_redir && m_flush < CNT_MAX) m_flush++;
        m_drop = e_drop;
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        check("hang_err", 64'(hang_err), 64'(m_hang));
    endtask

    task automatic idle(input logic iv);
        cyc(NOP_INSTR, 1'b0, 5'd0, 1'b0, iv, 1'b0, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; its effect must be visible before any edge.
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst             = 1'b0;
        if_id_instr     = NOP_INSTR;
        id_ex_mem_read  = 1'b0;
        id_ex_rd        = 5'd0;
        ex_branch_taken = 1'b0;
        imem_valid      = 1'b1;
        mem_access      = 1'b0;
        dmem_ready      = 1'b1;
        #1;
        check("rst_ctrl", 64'(obs_ctrl), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_flush", 64'(flush_cnt), 64'd0);
        check("rst_hang", 64'(hang_err), 64'd0);
        m_drop  = 1'b0;
        m_stall = 0;
        m_flush = 0;
        m_run   = 0;
        m_hang  = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rand_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_S, OP_B, 7'b0010011, 7'b0000011};

        do_reset();

        // Load-use: add x2,x1,x2 behind a load to x1.
        cyc(32'h00208133, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("lu_ctrl", 64'(last_ctrl), 64'(C_LOADUSE));
        check("lu_stall", 64'(stall_cnt), 64'd1);
        idle(1'b1);

        // No false hazards: rd=x0, and lui whose rs1 field aliases rd.
        cyc(NOP_INSTR, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("nohz_x0", 64'(last_ctrl), 64'(C_NORMAL));
        cyc(32'h000080B7, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("nohz_lui", 64'(last_ctrl), 64'(C_NORMAL));
        check("nohz_stall", 64'(stall_cnt), 64'd1);

        // Redirect with fetch available: stays in RUN.
        cyc(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("redir_ctrl", 64'(last_ctrl), 64'(C_REDIRECT));
        check("redir_flush", 64'(flush_cnt), 64'd1);
        idle(1'b1);
        check("redir_run", 64'(last_ctrl), 64'(C_NORMAL));

        // Redirect while fetch outstanding -> DROP for 3 cycles.
        cyc(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("drop_c1", 64'(last_ctrl), 64'(C_DROP));
        idle(1'b0);
        idle(1'b1);
        check("drop_c3", 64'(last_ctrl), 64'(C_DROP));
        check("drop_stall", 64'(stall_cnt), 64'd4);
        idle(1'b1);
        check("drop_exit", 64'(last_ctrl), 64'(C_NORMAL));

        // Data-memory wait masks a pending redirect for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            cyc(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            check("dmem_freeze", 64'(last_ctrl), 64'(C_FREEZE));
        end
        check("dmem_flush_held", 64'(flush_cnt), 64'd2);
        cyc(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("dmem_release", 64'(last_ctrl), 64'(C_REDIRECT));
        check("dmem_flush", 64'(flush_cnt), 64'd3);

        // Reset pulsed while in DROP.
        cyc(NOP_INSTR, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        idle(1'b1);
        check("rst_run", 64'(last_ctrl), 64'(C_NORMAL));

        // Watchdog: TIMEOUT consecutive stall cycles, counters saturate on the way.
        for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b0);
        check("wd_below", 64'(hang_err), 64'd0);
        idle(1'b0);
        check("wd_hit", 64'(hang_err), 64'd1);
        check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
        idle(1'b1);
        check("wd_sticky", 64'(hang_err), 64'd1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] instr;
            instr = {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'd0, 5'd5,
                     rand_ops[$urandom_range(0, 7)]};
            cyc(instr,
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RISC-V core.
- Drives the enable and flush controls of PC, IF_ID_Stage, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken-branch redirects, instruction-fetch waits and data-memory waits.
- A small FSM discards a wrong-path fetch that is still in flight when a redirect occurs; stall/flush counters and a hang watchdog support debug.

Parameters:
- CNT_W, 32, width of the performance counters (saturating).
- TIMEOUT, 1024, consecutive stall cycles before hang_err is set.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset; rst=0 resets.
- if_id_instr  in  32  instruction currently held in IF_ID_Stage.
- id_ex_mem_read  in  1  instruction in ID/EX is a load.
- id_ex_rd  in  5  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- imem_valid  in  1  instruction for the current PC is available this cycle.
- mem_access  in  1  EX/MEM holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF_ID_Stage write enable.
- if_id_flush  out  1  write a NOP (32'h00000013) into IF_ID_Stage.
- id_ex_en  out  1  ID/EX write enable.
- id_ex_flush  out  1  write a bubble into ID/EX.
- ex_mem_en  out  1  EX/MEM write enable.
- mem_wb_bubble  out  1  write a bubble into MEM/WB.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  redirects acted on.
- hang_err  out  1  sticky watchdog flag.

Behaviour:
- All enable and flush outputs are combinational from state and inputs. Counters, FSM state and the watchdog are registered.
- Reset (rst=0, asynchronous):
  - state=RUN, stall_cnt=0, flush_cnt=0, hang_err=0, watchdog=0.
  - While reset is asserted, all enables=0 and all flushes/bubbles=0.
  - Reset mid-stall abandons the stall and any pending drop.
- Decode of if_id_instr:
  - rs1=[19:15], rs2=[24:20].
  - uses_rs1 is false for opcodes 0110111, 0010111 and 1101111; true otherwise.
  - uses_rs2 is true for opcodes 0110011, 0100011 and 1100011.
- Default each cycle: all enables=1, all flushes/bubbles=0.
- Priority, highest first, one action per cycle:
  - P1, data-memory wait (mem_access && !dmem_ready):
    - pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_bubble=1.
    - ex_branch_taken is ignored because EX is frozen; it is re-presented once released.
  - P2, redirect (ex_branch_taken):
    - pc_en=1 (target loaded), if_id_flush=1, id_ex_flush=1; flush_cnt increments.
    - If imem_valid=0 in this cycle, next state is DROP.
  - P3, load-use:
    - Condition: id_ex_mem_read && id_ex_rd!=0 && ((uses_rs1 && rd==rs1) || (uses_rs2 && rd==rs2)).
    - Response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle per hazard.
  - P4, fetch wait (imem_valid=0 in RUN): pc_en=0, if_id_flush=1; downstream stages advance.
- FSM states:
  - RUN: normal sequencing as above.
  - DROP: the stale in-flight fetch has not yet returned.
    - Every cycle in DROP: pc_en=0, if_id_flush=1.
    - The first cycle with imem_valid=1 discards that fetch and returns to RUN.
    - P1 still applies on top of DROP.
    - Another redirect while in DROP re-asserts the P2 outputs and stays in DROP.
- stall_cnt increments on any cycle with pc_en=0 (rst=1); flush_cnt as in P2; both saturate at all-ones.
- Watchdog:
  - Increments on each consecutive cycle with pc_en=0; clears on any cycle with pc_en=1.
  - Reaching TIMEOUT sets hang_err; only reset clears it.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the opcode constants OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_S and OP_B;
  - NOP_INSTR = 32'h00000013;
  - the enum hz_state_t {RUN, DROP}.
- One natural sub-module: hazard_sat_counter, a parameterised saturating counter instanced twice.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=1, if_id_instr=32'h00208133 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1.
- No false hazard: id_ex_rd=0 with 32'h00000013, or id_ex_rd=1 with 32'h000080B7 (lui, rs1 field=1) -> no stall.
- Redirect: ex_branch_taken=1 with imem_valid=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1 in the same cycle; flush_cnt=1; state stays RUN.
- Drop:
  - Stimulus: ex_branch_taken=1 with imem_valid=0, then imem_valid=0 for 2 cycles, then 1.
  - Response: DROP lasts 3 cycles; the response on imem_valid=1 is flushed; RUN next; stall_cnt=3.
- Data-memory wait: mem_access=1, dmem_ready=0 for 4 cycles with ex_branch_taken=1 -> pipeline frozen and mem_wb_bubble=1 for 4 cycles; the redirect acts on the 5th cycle.
- Watchdog and reset:
  - imem_valid=0 for TIMEOUT cycles -> hang_err=1.
  - rst=0 pulsed mid-DROP -> state RUN, counters 0, hang_err 0 immediately, without waiting for a clock edge.
